// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes,
// ALU-control codes and the sequencer state type.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_BR    = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_MEM_WB,
        S_ALU_WB,
        S_BRANCH,
        S_HALT
    } state_t;

endpackage

// File: rtl/mc_watchdog.sv
// Memory-wait watchdog: counts consecutive cycles a request waits for
// mem_ready and flags expiry on the MEM_TIMEOUT-th unanswered cycle.
module mc_watchdog #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic busy,
    input  logic mem_ready,
    output logic expired
);

    logic [7:0] cnt;

    // Idle or completed cycles clear the count, so every new request starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (busy && !mem_ready) begin
            cnt <= cnt + 8'd1;
        end else begin
            cnt <= '0;
        end
    end

    assign expired = busy && !mem_ready && (cnt == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencer for a multi-cycle RV32I datapath sharing one memory port;
// outputs decode the state, qualified by mem_ready for handshake enables.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned RET_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_sel,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic             mdr_write,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             branch,
    output logic             illegal_instr,
    output logic             bus_error,
    output logic             halted,
    output logic [RET_W-1:0] retired
);

    state_t state, state_nxt;
    logic   is_load;
    logic   wd_busy, wd_expired;
    logic   retire, set_illegal, set_bus;

    assign wd_busy = (state inside {S_FETCH, S_MEM_RD, S_MEM_WR});

    mc_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .busy      (wd_busy),
        .mem_ready (mem_ready),
        .expired   (wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // LW/SW share MEM_ADDR, so the load/store choice is latched at decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_load <= 1'b0;
        end else if (state == S_DECODE) begin
            is_load <= (opcode == OP_LW);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_instr <= 1'b0;
            bus_error     <= 1'b0;
            retired       <= '0;
        end else begin
            if (set_illegal) illegal_instr <= 1'b1;
            if (set_bus)     bus_error     <= 1'b1;
            if (retire)      retired       <= retired + RET_W'(1);
        end
    end

    always_comb begin
        state_nxt   = state;
        mem_req     = 1'b0;
        mem_sel     = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        mdr_write   = 1'b0;
        alu_src     = 1'b0;
        alu_op      = ALU_OP_ADD;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        branch      = 1'b0;
        halted      = 1'b0;
        retire      = 1'b0;
        set_illegal = 1'b0;
        set_bus     = 1'b0;
        case (state)
            S_IDLE: state_nxt = S_FETCH;
            S_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
                if (mem_ready) begin
                    state_nxt = S_DECODE;
                end else if (wd_expired) begin
                    state_nxt = S_HALT;
                    set_bus   = 1'b1;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:         state_nxt = S_EXEC_R;
                    OP_I:         state_nxt = S_EXEC_I;
                    OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
                    OP_BR:        state_nxt = S_BRANCH;
                    default: begin
                        state_nxt   = S_HALT;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_op    = ALU_OP_FUNCT;
                state_nxt = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src   = 1'b1;
                alu_op    = ALU_OP_FUNCT;
                state_nxt = S_ALU_WB;
            end
            S_MEM_ADDR: begin
                alu_src   = 1'b1;
                state_nxt = is_load ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req   = 1'b1;
                mem_sel   = 1'b1;
                mem_read  = 1'b1;
                mdr_write = mem_ready;
                if (mem_ready) begin
                    state_nxt = S_MEM_WB;
                end else if (wd_expired) begin
                    state_nxt = S_HALT;
                    set_bus   = 1'b1;
                end
            end
            S_MEM_WR: begin
                mem_req   = 1'b1;
                mem_sel   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    state_nxt = S_FETCH;
                    retire    = 1'b1;
                end else if (wd_expired) begin
                    state_nxt = S_HALT;
                    set_bus   = 1'b1;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_nxt  = S_FETCH;
                retire     = 1'b1;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                state_nxt = S_FETCH;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_op    = ALU_OP_BR;
                branch    = 1'b1;
                state_nxt = S_FETCH;
                retire    = 1'b1;
            end
            S_HALT: halted = 1'b1;
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a step-queue model of each
// instruction's micro-steps is compared against the DUT on every falling edge.
module tb_multicycle_controller;

    localparam int unsigned TMO = 4;
    localparam int unsigned RW  = 4;

    localparam logic [6:0] R_OP  = 7'b0110011;
    localparam logic [6:0] I_OP  = 7'b0010011;
    localparam logic [6:0] LW_OP = 7'b0000011;
    localparam logic [6:0] SW_OP = 7'b0100011;
    localparam logic [6:0] BR_OP = 7'b1100011;
    localparam logic [6:0] BAD   = 7'b1111111;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [6:0]    opcode = '0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_sel, mem_read, mem_write, ir_write, pc_write;
    logic          mdr_write, alu_src, mem_to_reg, reg_write, branch;
    logic          illegal_instr, bus_error, halted;
    logic [1:0]    alu_op;
    logic [RW-1:0] retired;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.MEM_TIMEOUT(TMO), .RET_W(RW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_sel       (mem_sel),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .mdr_write     (mdr_write),
        .alu_src       (alu_src),
        .alu_op        (alu_op),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .branch        (branch),
        .illegal_instr (illegal_instr),
        .bus_error     (bus_error),
        .halted        (halted),
        .retired       (retired)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {P_OFF, P_FETCH, P_DECODE, P_ALU_R, P_ALU_I, P_ADDR, P_LOAD,
                  P_STORE, P_LWB, P_AWB, P_BEQ, P_DEAD} phase_e;

    phase_e      m_cur = P_OFF;
    phase_e      m_todo[$];
    int          m_wait = 0;
    logic        m_ill = 1'b0;
    logic        m_bus = 1'b0;
    int unsigned m_ret = 0;

    task automatic finish_step();
        if (m_todo.size() == 0) begin
            m_ret = (m_ret + 1) % (1 << RW);
            m_cur = P_FETCH;
        end else begin
            m_cur = m_todo.pop_front();
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cur = P_OFF;
            m_todo.delete();
            m_wait = 0;
            m_ill = 1'b0;
            m_bus = 1'b0;
            m_ret = 0;
        end else begin
            case (m_cur)
                P_OFF: m_cur = P_FETCH;
                P_FETCH, P_LOAD, P_STORE: begin
                    if (mem_ready) begin
                        m_wait = 0;
                        if (m_cur == P_FETCH) m_cur = P_DECODE;
                        else finish_step();
                    end else begin
                        m_wait++;
                        if (m_wait >= TMO) begin
                            m_cur = P_DEAD;
                            m_bus = 1'b1;
                        end
                    end
                end
                P_DECODE: begin
                    case (opcode)
                        R_OP:  begin m_todo = {P_AWB};         m_cur = P_ALU_R; end
                        I_OP:  begin m_todo = {P_AWB};         m_cur = P_ALU_I; end
                        LW_OP: begin m_todo = {P_LOAD, P_LWB}; m_cur = P_ADDR;  end
                        SW_OP: begin m_todo = {P_STORE};       m_cur = P_ADDR;  end
                        BR_OP: begin m_todo.delete();          m_cur = P_BEQ;   end
                        default: begin m_cur = P_DEAD; m_ill = 1'b1; end
                    endcase
                end
                P_DEAD: ;
                default: finish_step();
            endcase
        end
    end

    // {req, sel, read, write, ir_w, pc_w, mdr_w, alu_src, alu_op[1:0], m2r, reg_w, branch, halted}
    function automatic logic [13:0] expect_vec(input phase_e p, input logic rdy);
        logic req, sel, rd, wr, irw, pcw, mdrw, src, m2r, rw, br, hlt;
        logic [1:0] op;
        {req, sel, rd, wr, irw, pcw, mdrw, src, m2r, rw, br, hlt} = '0;
        op = 2'b00;
        case (p)
            P_FETCH: begin req = 1; irw = rdy; pcw = rdy; end
            P_ALU_R: op = 2'b10;
            P_ALU_I: begin src = 1; op = 2'b10; end
            P_ADDR:  src = 1;
            P_LOAD:  begin req = 1; sel = 1; rd = 1; mdrw = rdy; end
            P_STORE: begin req = 1; sel = 1; wr = 1; end
            P_LWB:   begin m2r = 1; rw = 1; end
            P_AWB:   rw = 1;
            P_BEQ:   begin op = 2'b01; br = 1; end
            P_DEAD:  hlt = 1;
            default: ;
        endcase
        return {req, sel, rd, wr, irw, pcw, mdrw, src, op, m2r, rw, br, hlt};
    endfunction

    logic [13:0] act_vec;
    assign act_vec = {mem_req, mem_sel, mem_read, mem_write, ir_write, pc_write, mdr_write,
                      alu_src, alu_op, mem_to_reg, reg_write, branch, halted};

    always @(negedge clk) begin
        chk("outputs", 32'(act_vec), 32'(expect_vec(m_cur, mem_ready)));
        chk("flags", {30'b0, illegal_instr, bus_error}, {30'b0, m_ill, m_bus});
        chk("retired", 32'(retired), m_ret);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input logic [6:0] op, input logic rdy);
        opcode    = op;
        mem_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", 32'({act_vec, illegal_instr, bus_error}), 32'd0);
        chk("reset_retired", 32'(retired), 32'd0);
        #2 rst_n = 1'b1;

        // R-type, zero wait
        tick(R_OP, 1);                   // IDLE -> FETCH
        tick(R_OP, 1);                   // -> DECODE
        tick(R_OP, 1);                   // -> EXEC_R
        tick(R_OP, 1);                   // -> ALU_WB
        chk("r_wb_regwrite", 32'(reg_write), 32'd1);
        tick(R_OP, 1);                   // -> FETCH
        chk("r_retired", 32'(retired), 32'd1);
        chk("model_ret_pin", m_ret, 32'd1);

        // I-type
        tick(I_OP, 1);
        tick(I_OP, 1);                   // EXEC_I
        chk("i_alu", 32'({alu_src, alu_op}), 32'b110);
        tick(I_OP, 1);
        tick(I_OP, 1);
        chk("i_retired", 32'(retired), 32'd2);

        // LW with mem_ready arriving on the 4th MEM_RD cycle (timeout boundary)
        tick(LW_OP, 1);
        tick(LW_OP, 1);                  // MEM_ADDR
        tick(LW_OP, 1);                  // MEM_RD
        repeat (3) tick(LW_OP, 0);
        tick(LW_OP, 1);                  // MEM_WB
        chk("lw_wb", 32'({mem_to_reg, reg_write}), 32'b11);
        chk("lw_no_buserr", 32'(bus_error), 32'd0);
        tick(LW_OP, 1);
        chk("lw_retired", 32'(retired), 32'd3);

        // SW then BEQ, zero wait
        tick(SW_OP, 1);
        tick(SW_OP, 1);
        tick(SW_OP, 1);                  // MEM_WR
        tick(SW_OP, 1);                  // FETCH
        tick(BR_OP, 1);
        tick(BR_OP, 1);                  // BRANCH
        chk("beq_branch", 32'({branch, alu_op}), 32'b101);
        tick(BR_OP, 1);
        chk("sw_beq_retired", 32'(retired), 32'd5);

        // FETCH ready on the 4th waiting cycle: no error
        repeat (3) tick(R_OP, 0);
        tick(R_OP, 1);                   // DECODE
        chk("late_ready_ok", 32'({bus_error, halted}), 32'd0);
        tick(R_OP, 1);
        tick(R_OP, 1);
        tick(R_OP, 1);
        chk("late_retired", 32'(retired), 32'd6);

        // FETCH never ready: timeout into HALT
        repeat (4) tick(R_OP, 0);
        chk("timeout_halt", 32'({halted, bus_error, illegal_instr}), 32'b110);
        tick(R_OP, 1);
        tick(R_OP, 0);
        tick(R_OP, 1);
        chk("halt_sticky", 32'({halted, retired}), {27'b0, 1'b1, 4'd6});

        // illegal opcode
        rst_n = 1'b0;
        #2;
        chk("async_reset_halt", 32'({act_vec, illegal_instr, bus_error}), 32'd0);
        tick(BAD, 0);
        tick(BAD, 0);
        rst_n = 1'b1;
        tick(BAD, 1);                    // FETCH
        tick(BAD, 1);                    // DECODE
        tick(BAD, 1);                    // HALT
        chk("illegal_halt", 32'({halted, illegal_instr, bus_error}), 32'b110);
        chk("illegal_retired", 32'(retired), 32'd0);
        tick(BAD, 1);
        tick(BAD, 0);

        // retired counter wrap (RET_W = 4)
        rst_n = 1'b0;
        tick(BR_OP, 0);
        rst_n = 1'b1;
        tick(BR_OP, 1);                  // FETCH
        for (int i = 0; i < 17; i++) begin
            tick(BR_OP, 1);
            tick(BR_OP, 1);
            tick(BR_OP, 1);
            if (i == 15) chk("wrap_zero", 32'(retired), 32'd0);
        end
        chk("wrap_one", 32'(retired), 32'd1);

        // async reset in the middle of a stalled MEM_RD
        tick(LW_OP, 1);
        tick(LW_OP, 1);                  // MEM_ADDR
        tick(LW_OP, 0);                  // MEM_RD
        tick(LW_OP, 0);
        chk("mid_rd_req", 32'({mem_req, mem_sel, mem_read}), 32'b111);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rd_reset_outs", 32'({act_vec, illegal_instr, bus_error}), 32'd0);
        chk("mid_rd_reset_ret", 32'(retired), 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("resume_fetch", 32'({mem_req, mem_sel, halted}), 32'b100);
        tick(R_OP, 1);
        tick(R_OP, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
